// File: rtl/v_wb_queue.sv
// Writeback queue between vector execute and the vector register file write port.
// Latency: an accepted result is presented on vreg_*_o one cycle after acceptance (no bypass).
// Backpressure: ex_ready_o drops only when full and depends solely on the registered count.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush_i           squash all buffered results (takes effect at the next edge)
//   ex_valid_i/ex_ready_o, ex_wen_i, ex_waddr_i, ex_result_i   execute-side handshake
//   wb_ready_i        regfile write port free this cycle
//   vreg_wen_o, vreg_waddr_o, vreg_wdata_o                     head entry / regfile write
//   count_o           buffered entry count, registered
// Optional feature (macro V_WB_FWD_EN): fwd_raddr_i, fwd_hit_o, fwd_data_o give a
// combinational youngest-match lookup of buffered results by destination index.
module v_wb_queue #(
    parameter int VREG_W = 256,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              ex_wen_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [VREG_W-1:0] ex_result_i,
    input  logic              wb_ready_i,
    output logic              vreg_wen_o,
    output logic [ADDR_W-1:0] vreg_waddr_o,
    output logic [VREG_W-1:0] vreg_wdata_o,
`ifdef V_WB_FWD_EN
    input  logic [ADDR_W-1:0] fwd_raddr_i,
    output logic              fwd_hit_o,
    output logic [VREG_W-1:0] fwd_data_o,
`endif
    output logic [PTR_W:0]    count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [VREG_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic empty;
    logic push;
    logic drain;

    assign empty      = (count == '0);
    assign ex_ready_o = (count != FULL_CNT);
    // A no-write op completes the handshake but never occupies a slot.
    assign push       = ex_valid_i & ex_ready_o & ex_wen_i;

    assign vreg_wen_o   = ~empty;
    assign vreg_waddr_o = empty ? '0 : mem_addr[rd_ptr];
    assign vreg_wdata_o = empty ? '0 : mem_data[rd_ptr];
    assign drain        = vreg_wen_o & wb_ready_i;

    assign count_o = count;

    // Pointer/count state. Flush and reset are equivalent: they override any
    // same-cycle push or drain. The regfile still sees the head write during a
    // flush cycle because vreg_wen_o is combinational from current state.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drain) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: every read of it is masked by the count.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush_i) begin
            mem_addr[wr_ptr] <= ex_waddr_i;
            mem_data[wr_ptr] <= ex_result_i;
        end
    end

`ifdef V_WB_FWD_EN
    // Walk entries oldest to youngest; later matches overwrite earlier ones so
    // the youngest buffered write to the index wins.
    logic [PTR_W-1:0] fwd_idx;

    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) && (mem_addr[fwd_idx] == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = mem_data[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_v_wb_queue.sv
// Directed bench for v_wb_queue.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
// Forwarding checks are compiled in only when V_WB_FWD_EN is defined.
module tb_v_wb_queue;

    localparam int VREG_W = 256;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic              ex_wen_i;
    logic [ADDR_W-1:0] ex_waddr_i;
    logic [VREG_W-1:0] ex_result_i;
    logic              wb_ready_i;
    logic              vreg_wen_o;
    logic [ADDR_W-1:0] vreg_waddr_o;
    logic [VREG_W-1:0] vreg_wdata_o;
    logic [PTR_W:0]    count_o;
`ifdef V_WB_FWD_EN
    logic [ADDR_W-1:0] fwd_raddr_i;
    logic              fwd_hit_o;
    logic [VREG_W-1:0] fwd_data_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    v_wb_queue #(.VREG_W(VREG_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_wen_i     (ex_wen_i),
        .ex_waddr_i   (ex_waddr_i),
        .ex_result_i  (ex_result_i),
        .wb_ready_i   (wb_ready_i),
        .vreg_wen_o   (vreg_wen_o),
        .vreg_waddr_o (vreg_waddr_o),
        .vreg_wdata_o (vreg_wdata_o),
`ifdef V_WB_FWD_EN
        .fwd_raddr_i  (fwd_raddr_i),
        .fwd_hit_o    (fwd_hit_o),
        .fwd_data_o   (fwd_data_o),
`endif
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VREG_W-1:0] pat(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic push_one(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        ex_valid_i  = 1'b1;
        ex_wen_i    = 1'b1;
        ex_waddr_i  = a;
        ex_result_i = pat(w);
        step();
        ex_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        n_checks++; if (vreg_wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%0h exp=0", vreg_wen_o); end
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        n_checks++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0h exp=1", ex_ready_o); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        wb_ready_i = 1'b1;
        push_one(5'd3, 32'h0000_0005);
        n_checks++; if (vreg_wen_o !== 1'b1) begin n_fail++; $display("FAIL write_wen got=%0h exp=1", vreg_wen_o); end
        n_checks++; if (vreg_waddr_o !== 5'd3) begin n_fail++; $display("FAIL write_waddr got=%0d exp=3", vreg_waddr_o); end
        n_checks++; if (vreg_wdata_o !== pat(32'h5)) begin n_fail++; $display("FAIL write_wdata got=%h exp=%h", vreg_wdata_o, pat(32'h5)); end
        n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL write_count1 got=%0d exp=1", count_o); end
        step();
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL write_count0 got=%0d exp=0", count_o); end
        n_checks++; if (vreg_wen_o !== 1'b0) begin n_fail++; $display("FAIL write_wen_after got=%0h exp=0", vreg_wen_o); end
    endtask

    task automatic test_full();
        wb_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(ADDR_W'(i), 32'h100 + 32'(i));
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", count_o); end
        n_checks++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0h exp=0", ex_ready_o); end
        push_one(5'd9, 32'h999);
        n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL full_reject got=%0d exp=4", count_o); end
        wb_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (vreg_wen_o !== 1'b1 || vreg_waddr_o !== ADDR_W'(i))
                begin n_fail++; $display("FAIL full_order[%0d] wen=%0h waddr=%0d exp waddr=%0d", i, vreg_wen_o, vreg_waddr_o, i); end
            n_checks++; if (vreg_wdata_o !== pat(32'h100 + 32'(i)))
                begin n_fail++; $display("FAIL full_data[%0d] got=%h exp=%h", i, vreg_wdata_o, pat(32'h100 + 32'(i))); end
            step();
        end
        n_checks++; if (count_o !== 3'd0 || vreg_wen_o !== 1'b0) begin n_fail++; $display("FAIL full_empty count=%0d wen=%0h exp 0/0", count_o, vreg_wen_o); end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_full_drain_push();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_one(ADDR_W'(10 + i), 32'h200 + 32'(i));
        wb_ready_i  = 1'b1;
        ex_valid_i  = 1'b1;
        ex_waddr_i  = 5'd20;
        ex_result_i = pat(32'hDEAD);
        n_checks++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL fdp_ready_full got=%0h exp=0", ex_ready_o); end
        step();
        ex_valid_i = 1'b0;
        wb_ready_i = 1'b0;
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL fdp_count got=%0d exp=3", count_o); end
        n_checks++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL fdp_ready got=%0h exp=1", ex_ready_o); end
        n_checks++; if (vreg_waddr_o !== 5'd11) begin n_fail++; $display("FAIL fdp_head got=%0d exp=11", vreg_waddr_o); end
        wb_ready_i = 1'b1;
        repeat (3) step();
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL fdp_drained got=%0d exp=0", count_o); end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_nowrite();
        ex_valid_i = 1'b1;
        ex_wen_i   = 1'b0;
        ex_waddr_i = 5'd7;
        n_checks++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL nowrite_ready got=%0h exp=1", ex_ready_o); end
        step();
        ex_valid_i = 1'b0;
        ex_wen_i   = 1'b1;
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL nowrite_count got=%0d exp=0", count_o); end
        n_checks++; if (vreg_wen_o !== 1'b0) begin n_fail++; $display("FAIL nowrite_wen got=%0h exp=0", vreg_wen_o); end
    endtask

    task automatic test_back_to_back();
        wb_ready_i = 1'b1;
        push_one(5'd21, 32'h21);
        n_checks++; if (count_o !== 3'd1 || vreg_waddr_o !== 5'd21) begin n_fail++; $display("FAIL b2b_first count=%0d waddr=%0d exp 1/21", count_o, vreg_waddr_o); end
        push_one(5'd22, 32'h22);
        n_checks++; if (count_o !== 3'd1 || vreg_waddr_o !== 5'd22) begin n_fail++; $display("FAIL b2b_second count=%0d waddr=%0d exp 1/22", count_o, vreg_waddr_o); end
        n_checks++; if (vreg_wdata_o !== pat(32'h22)) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", vreg_wdata_o, pat(32'h22)); end
        step();
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL b2b_empty got=%0d exp=0", count_o); end
        wb_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push_one(ADDR_W'(i), 32'h300 + 32'(i));
        n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", count_o); end
        n_checks++; if (vreg_wen_o !== 1'b1 || vreg_waddr_o !== 5'd0) begin n_fail++; $display("FAIL flush_vd0_head wen=%0h waddr=%0d exp 1/0", vreg_wen_o, vreg_waddr_o); end
`ifdef V_WB_FWD_EN
        fwd_raddr_i = 5'd1;
        #1;
        n_checks++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== pat(32'h301)) begin n_fail++; $display("FAIL flush_pre_fwd hit=%0h data=%h", fwd_hit_o, fwd_data_o); end
`endif
        flush_i     = 1'b1;
        ex_valid_i  = 1'b1;
        ex_wen_i    = 1'b1;
        ex_waddr_i  = 5'd6;
        ex_result_i = pat(32'h666);
        step();
        flush_i    = 1'b0;
        ex_valid_i = 1'b0;
        n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count_o); end
        n_checks++; if (vreg_wen_o !== 1'b0 || vreg_waddr_o !== 5'd0 || vreg_wdata_o !== '0)
            begin n_fail++; $display("FAIL flush_head wen=%0h waddr=%0d exp 0/0 data0", vreg_wen_o, vreg_waddr_o); end
`ifdef V_WB_FWD_EN
        n_checks++; if (fwd_hit_o !== 1'b0) begin n_fail++; $display("FAIL flush_fwd got=%0h exp=0", fwd_hit_o); end
`endif
        push_one(5'd8, 32'h8);
        push_one(5'd9, 32'h9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (count_o !== 3'd0 || vreg_wen_o !== 1'b0) begin n_fail++; $display("FAIL midrst count=%0d wen=%0h exp 0/0", count_o, vreg_wen_o); end
    endtask

`ifdef V_WB_FWD_EN
    task automatic test_fwd();
        wb_ready_i = 1'b0;
        push_one(5'd5, 32'hAAAA_AAAA);
        push_one(5'd5, 32'hBBBB_BBBB);
        push_one(5'd7, 32'hCCCC_CCCC);
        fwd_raddr_i = 5'd5;
        #1;
        n_checks++; if (fwd_hit_o !== 1'b1) begin n_fail++; $display("FAIL fwd_hit got=%0h exp=1", fwd_hit_o); end
        n_checks++; if (fwd_data_o !== pat(32'hBBBB_BBBB)) begin n_fail++; $display("FAIL fwd_youngest got=%h exp=%h", fwd_data_o, pat(32'hBBBB_BBBB)); end
        fwd_raddr_i = 5'd9;
        #1;
        n_checks++; if (fwd_hit_o !== 1'b0 || fwd_data_o !== '0) begin n_fail++; $display("FAIL fwd_miss hit=%0h exp=0", fwd_hit_o); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask
`endif

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        ex_valid_i  = 1'b0;
        ex_wen_i    = 1'b1;
        ex_waddr_i  = '0;
        ex_result_i = '0;
        wb_ready_i  = 1'b0;
`ifdef V_WB_FWD_EN
        fwd_raddr_i = '0;
`endif
        #1;
        test_reset();
        test_write();
        test_full();
        test_full_drain_push();
        test_nowrite();
        test_back_to_back();
        test_flush();
`ifdef V_WB_FWD_EN
        test_fwd();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
